fft_bfly_sched: RTL and testbench

FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

---
 rtl/fft_bfly_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_fft_bfly_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched.sv
// -----------------------------------------------------------------------------
// fft_bfly_sched
//   32-point radix-2 DIT FFT scheduler. It holds the working array, loads
//   samples in bit-reversed order, issues one butterfly per cycle to an
//   external multiply/add stage, writes the results back, and then unloads
//   the bins in natural order.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready, in_real/img   7-bit signed time-domain sample load
//   x_*, y_*                         butterfly operands (x multiplied, y upper)
//   w_real/w_img                     Q1.10 twiddle for the issued butterfly
//   out1_*, out2_*                   external results y+wx, y-wx (combinational)
//   out_valid/out_ready              bin unload handshake
//   out_real/out_img, out_index      bin value and index
//   busy                             high while butterflies are being run
// -----------------------------------------------------------------------------
module fft_bfly_sched #(
    parameter int number_bits = 22,
    parameter int Q           = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_real,
    input  logic [6:0]             in_img,
    output logic [number_bits-1:0] x_real,
    output logic [number_bits-1:0] x_img,
    output logic [number_bits-1:0] y_real,
    output logic [number_bits-1:0] y_img,
    output logic [Q-1:0]           w_real,
    output logic [Q-1:0]           w_img,
    input  logic [number_bits-1:0] out1_real,
    input  logic [number_bits-1:0] out1_img,
    input  logic [number_bits-1:0] out2_real,
    input  logic [number_bits-1:0] out2_img,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [number_bits-1:0] out_real,
    output logic [number_bits-1:0] out_img,
    output logic [4:0]             out_index,
    output logic                   busy
);

    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

    state_t state, state_nx;

    logic [number_bits-1:0] mem_re [32];
    logic [number_bits-1:0] mem_im [32];

    logic [4:0] load_cnt;
    logic [4:0] unload_cnt;
    logic [2:0] stage;
    logic [4:0] k_cnt;      // 0..15 issue slots, 16 is the stage bubble

    logic [4:0] half, k5, j, top, bot;
    logic [3:0] tw_idx;
    logic       issue;

    logic       wb_valid;
    logic [4:0] wb_top, wb_bot;

    function automatic logic [4:0] bitrev5(input logic [4:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // round(cos(2*pi*i/32)*1024)
    function automatic logic [Q-1:0] tw_rom_re(input logic [3:0] i);
        case (i)
            4'd0:    return Q'(1024);
            4'd1:    return Q'(1004);
            4'd2:    return Q'(946);
            4'd3:    return Q'(851);
            4'd4:    return Q'(724);
            4'd5:    return Q'(569);
            4'd6:    return Q'(392);
            4'd7:    return Q'(200);
            4'd8:    return Q'(0);
            4'd9:    return Q'(-200);
            4'd10:   return Q'(-392);
            4'd11:   return Q'(-569);
            4'd12:   return Q'(-724);
            4'd13:   return Q'(-851);
            4'd14:   return Q'(-946);
            default: return Q'(-1004);
        endcase
    endfunction

    // round(-sin(2*pi*i/32)*1024)
    function automatic logic [Q-1:0] tw_rom_im(input logic [3:0] i);
        case (i)
            4'd0:    return Q'(0);
            4'd1:    return Q'(-200);
            4'd2:    return Q'(-392);
            4'd3:    return Q'(-569);
            4'd4:    return Q'(-724);
            4'd5:    return Q'(-851);
            4'd6:    return Q'(-946);
            4'd7:    return Q'(-1004);
            4'd8:    return Q'(-1024);
            4'd9:    return Q'(-1004);
            4'd10:   return Q'(-946);
            4'd11:   return Q'(-851);
            4'd12:   return Q'(-724);
            4'd13:   return Q'(-569);
            4'd14:   return Q'(-392);
            default: return Q'(-200);
        endcase
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == 5'd31) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (stage == 3'd4 && k_cnt == 5'd16) state_nx = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && unload_cnt == 5'd31) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // ---------------- butterfly addressing ----------------
    always_comb begin
        k5     = {1'b0, k_cnt[3:0]};
        half   = 5'd1 << stage;
        j      = k5 & (half - 5'd1);
        top    = ((k5 >> stage) << (stage + 3'd1)) + j;
        bot    = top + half;
        tw_idx = 4'(j << (3'd4 - stage));
        issue  = (state == CALC) && !k_cnt[4];
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            unload_cnt <= '0;
            stage      <= '0;
            k_cnt      <= '0;
        end else begin
            case (state)
                LOAD:   if (in_valid) load_cnt <= load_cnt + 5'd1;
                CALC: begin
                    if (k_cnt == 5'd16) begin
                        k_cnt <= '0;
                        stage <= (stage == 3'd4) ? 3'd0 : stage + 3'd1;
                    end else begin
                        k_cnt <= k_cnt + 5'd1;
                    end
                end
                UNLOAD: if (out_ready) unload_cnt <= unload_cnt + 5'd1;
                default: ;
            endcase
        end
    end

    // ---------------- operand issue and writeback tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_real   <= '0;
            x_img    <= '0;
            y_real   <= '0;
            y_img    <= '0;
            w_real   <= '0;
            w_img    <= '0;
            wb_valid <= 1'b0;
            wb_top   <= '0;
            wb_bot   <= '0;
        end else begin
            wb_valid <= issue;
            if (issue) begin
                y_real <= mem_re[top];
                y_img  <= mem_im[top];
                x_real <= mem_re[bot];
                x_img  <= mem_im[bot];
                w_real <= tw_rom_re(tw_idx);
                w_img  <= tw_rom_im(tw_idx);
                wb_top <= top;
                wb_bot <= bot;
            end
        end
    end

    // ---------------- working array ----------------
    // The stage bubble (k_cnt==16) lets the last writeback of a stage land
    // before the next stage's first issue reads the array.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem_re[bitrev5(load_cnt)] <= {{(number_bits-18){in_real[6]}}, in_real, 11'b0};
            mem_im[bitrev5(load_cnt)] <= {{(number_bits-18){in_img[6]}},  in_img,  11'b0};
        end else if (state == CALC && wb_valid) begin
            mem_re[wb_top] <= out1_real;
            mem_im[wb_top] <= out1_img;
            mem_re[wb_bot] <= out2_real;
            mem_im[wb_bot] <= out2_img;
        end
    end

    assign out_index = unload_cnt;
    assign out_real  = mem_re[unload_cnt];
    assign out_img   = mem_im[unload_cnt];

endmodule

// File: tb/tb_fft_bfly_sched.sv
`timescale 1ns/1ps
module tb_fft_bfly_sched;

    localparam int NB = 22;
    localparam int QW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [6:0]    in_real, in_img;
    logic [NB-1:0] x_real, x_img, y_real, y_img;
    logic [QW-1:0] w_real, w_img;
    logic [NB-1:0] out1_real, out1_img, out2_real, out2_img;
    logic [NB-1:0] out_real, out_img;
    logic [4:0]    out_index;

    fft_bfly_sched #(.number_bits(NB), .Q(QW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_img(in_img),
        .x_real(x_real), .x_img(x_img), .y_real(y_real), .y_img(y_img),
        .w_real(w_real), .w_img(w_img),
        .out1_real(out1_real), .out1_img(out1_img),
        .out2_real(out2_real), .out2_img(out2_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_img(out_img), .out_index(out_index),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External multiply/add stage: y +/- (w*x >>> 10), wrapping to NB bits.
    always_comb begin
        longint xr, xi, yr, yi, wr, wi, pr, pi;
        xr = longint'($signed(x_real));
        xi = longint'($signed(x_img));
        yr = longint'($signed(y_real));
        yi = longint'($signed(y_img));
        wr = longint'($signed(w_real));
        wi = longint'($signed(w_img));
        pr = (wr * xr - wi * xi) >>> 10;
        pi = (wr * xi + wi * xr) >>> 10;
        out1_real = NB'(yr + pr);
        out1_img  = NB'(yi + pi);
        out2_real = NB'(yr - pr);
        out2_img  = NB'(yi - pi);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct {
        int     idx;
        longint re;
        longint im;
    } exp_t;

    exp_t sb[$];

    task automatic push_bin(input int idx, input longint re, input longint im);
        exp_t e;
        e.idx = idx;
        e.re  = re;
        e.im  = im;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic          stalled = 1'b0;
    logic [4:0]    h_idx;
    logic [NB-1:0] h_re, h_im;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                chk("hold_index", out_index, h_idx);
                chk("hold_real", out_real, h_re);
                chk("hold_img", out_img, h_im);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got bin %0d, expected no output", out_index);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bin_index", out_index, e.idx);
                    chk($sformatf("bin%0d_real", e.idx), longint'($signed(out_real)), e.re);
                    chk($sformatf("bin%0d_img", e.idx), longint'($signed(out_img)), e.im);
                end
            end
            stalled = out_valid && !out_ready;
            h_idx   = out_index;
            h_re    = out_real;
            h_im    = out_img;
        end
    end

    // ---------------- stimulus helpers ----------------
    int fr_re[32];
    int fr_im[32];

    localparam int COS_T[16] = '{1024, 1004, 946, 851, 724, 569, 392, 200,
                                 0, -200, -392, -569, -724, -851, -946, -1004};
    localparam int NSIN_T[16] = '{0, -200, -392, -569, -724, -851, -946, -1004,
                                  -1024, -1004, -946, -851, -724, -569, -392, -200};

    task automatic clear_frame();
        for (int i = 0; i < 32; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic load_frame(input bit gaps);
        for (int i = 0; i < 32; i++) begin
            if (gaps && (i % 7 == 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_real  = 7'(fr_re[i]);
            in_img   = 7'(fr_im[i]);
            if (i == 31) chk("in_ready_last_load", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_real  = '0;
        in_img   = '0;
    endtask

    // Called right after the 32nd acceptance edge; that acceptance cycle is 0.
    task automatic measure();
        int busy_n  = 0;
        int first_v = -1;
        bit ir_low  = 1'b1;
        for (int c = 1; c <= 120 && first_v < 0; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (in_ready) ir_low = 1'b0;
            if (out_valid) first_v = c;
        end
        chk("busy_cycles", busy_n, 85);
        chk("out_valid_latency", first_v, 86);
        chk("in_ready_low_calc", ir_low, 1);
        @(posedge clk); #1;
    endtask

    task automatic unload(input bit random_ready);
        int cyc = 0;
        while (sb.size() > 0 && cyc < 400) begin
            out_ready = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("unload_drained", sb.size(), 0);
        sb.delete();
        chk("in_ready_after_unload", in_ready, 1);
        chk("out_valid_after_unload", out_valid, 0);
        chk("out_index_after_unload", out_index, 0);
    endtask

    task automatic expect_impulse(input int a_re, input int a_im);
        for (int k = 0; k < 32; k++) push_bin(k, a_re * 2048, a_im * 2048);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_real   = '0;
        in_img    = '0;
        #2 rst_n  = 1'b0;
        #10;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_x_real", x_real, 0);
        chk("rst_w_real", w_real, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse at x[0]: flat spectrum of 2048.
        clear_frame();
        fr_re[0] = 1;
        expect_impulse(1, 0);
        load_frame(1'b0);
        measure();
        unload(1'b1);

        // DC: all energy in bin 0.
        clear_frame();
        for (int i = 0; i < 32; i++) fr_re[i] = 1;
        push_bin(0, 65536, 0);
        for (int k = 1; k < 32; k++) push_bin(k, 0, 0);
        load_frame(1'b1);
        measure();
        unload(1'b1);

        // Impulse at x[1]: bin k = 2048*W^k, which is exactly twice the twiddle.
        clear_frame();
        fr_re[1] = 1;
        for (int k = 0; k < 16; k++)  push_bin(k, 2 * COS_T[k], 2 * NSIN_T[k]);
        for (int k = 16; k < 32; k++) push_bin(k, -2 * COS_T[k-16], -2 * NSIN_T[k-16]);
        load_frame(1'b0);
        measure();
        unload(1'b1);

        // Complex negative impulse exercises sign extension of both parts.
        clear_frame();
        fr_re[0] = -3;
        fr_im[0] = 5;
        expect_impulse(-3, 5);
        load_frame(1'b1);
        unload(1'b0);

        // Abort mid-CALC, then a fresh impulse load must fully define the result.
        clear_frame();
        for (int i = 0; i < 32; i++) fr_re[i] = 7;
        load_frame(1'b0);
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_index", out_index, 0);
        chk("abort_y_img", y_img, 0);
        chk("abort_w_real", w_real, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_frame();
        fr_re[0] = 1;
        expect_impulse(1, 0);
        load_frame(1'b0);
        measure();
        unload(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
